fix_csum_gen: RTL and testbench
===============================

FIX_CSUM_GEN -- requirements
Module: fix_csum_gen

Interface
REQ-001 Parameter LANES, default 1, bytes per input beat (legal 1..8); lane 0 carries the earliest byte.
REQ-002 Parameter SEED, default 8'd0, initial sum preloaded on a start beat, covering header bytes already consumed upstream.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 data_i  input  8*LANES  message bytes; lane n at bits [8n+7:8n].
REQ-006 keep_i  input  LANES  per-lane byte enable; only lanes with keep set are summed.
REQ-007 valid_i  input  1  beat valid.
REQ-008 start_i  input  1  beat is the first beat of a message; qualified by valid_i.
REQ-009 end_i  input  1  beat is the last summed beat of a message; qualified by valid_i.
REQ-010 ready_o  output  1  block accepts a beat; a beat is accepted when valid_i and ready_o are both high.
REQ-011 digit_o  output  8  ASCII checksum digit, most significant first.
REQ-012 digit_valid_o  output  1  digit_o valid.
REQ-013 digit_ready_i  input  1  consumer accepts digit_o when digit_valid_o is also high.
REQ-014 digit_last_o  output  1  high with the third (units) digit.
REQ-015 busy_o  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, ACC, CONV, EMIT_H, EMIT_T and EMIT_U.
REQ-017 ready_o SHALL be high in IDLE and ACC, and low in CONV and all EMIT states.
REQ-018 In IDLE, an accepted beat with start_i low SHALL be ignored.
REQ-019 An accepted start beat SHALL set sum = (SEED + kept bytes of that beat) mod 256 and SHALL move to ACC.
REQ-020 An accepted start beat while in ACC SHALL discard the running sum and restart as in REQ-019.
REQ-021 In ACC, an accepted non-start beat SHALL add its kept bytes to sum, mod 256.
REQ-022 A beat with keep_i all zero SHALL leave sum unchanged, while still honouring start_i and end_i.
REQ-023 An accepted beat with end_i high SHALL include its own bytes, then move to CONV.
REQ-024 start_i and end_i may be high on the same beat; that is a single-beat message.
REQ-025 CONV SHALL last exactly one cycle, SHALL split the 8-bit sum into hundreds, tens and units digits (0..2, 0..9, 0..9), and SHALL then move to EMIT_H.
REQ-026 Latency: if the end beat is accepted at edge k, digit_valid_o SHALL be high from edge k+2.
REQ-027 Each EMIT state SHALL drive digit_o = 8'h30 + digit with digit_valid_o high.
REQ-028 Each EMIT state SHALL hold digit_o stable until digit_ready_i is high, then advance H→T→U→IDLE.
REQ-029 digit_last_o SHALL be high only in EMIT_U.
REQ-030 Leading zeros SHALL always be emitted; exactly three digits are sent per message.
REQ-031 valid_i, start_i and end_i SHALL be ignored outside IDLE and ACC.
REQ-032 A sum of 0 SHALL produce "000"; a sum of 255 SHALL produce "255".

Reset
REQ-033 While rst is low: state = IDLE, sum = 0, digit_o = 0, digit_valid_o = 0, digit_last_o = 0, busy_o = 0.
REQ-034 While rst is low, ready_o SHALL be 0.
REQ-035 Assertion of rst mid-message or mid-emit SHALL abort immediately; no further digits are emitted for that message.
REQ-036 After rst deasserts, the block SHALL wait in IDLE for a new start beat.

Configuration
REQ-037 With macro FIX_CSUM_CHECK_EN defined, the block SHALL add these ports:
- exp_csum_i  input  24  expected ASCII checksum, hundreds digit in [23:16].
- csum_ok_o  output  1  match pulse.
- csum_err_o  output  1  mismatch pulse.
REQ-038 With FIX_CSUM_CHECK_EN defined, exp_csum_i SHALL be sampled in CONV.
REQ-039 With FIX_CSUM_CHECK_EN defined, exactly one of csum_ok_o / csum_err_o SHALL pulse for one cycle on entry to EMIT_H.
REQ-040 With FIX_CSUM_CHECK_EN defined, both pulse outputs SHALL be 0 in reset.
REQ-041 Without FIX_CSUM_CHECK_EN, those three ports and the compare logic SHALL be absent; all other behaviour is identical.

Verification
REQ-042 LANES=1, SEED=0, bytes 0x41,0x42,0x43, end on the third, digit_ready_i=1 -> digits 0x31,0x39,0x38 ("198"), digit_last_o with 0x38, first digit 2 cycles after the end beat.
REQ-043 LANES=1, bytes 0xFF,0x02 -> sum wraps to 1 -> "001" (0x30,0x30,0x31).
REQ-044 LANES=4, single beat with start_i=end_i=1, keep_i=4'b0011, data 0xEE_DD_20_10 -> "048".
REQ-045 digit_ready_i low for 5 cycles in EMIT_T -> digit_o and digit_valid_o held stable, ready_o low throughout; rst low during EMIT_T -> all outputs 0 next cycle, no units digit emitted.
REQ-046 FIX_CSUM_CHECK_EN defined, message as REQ-042: exp_csum_i="198" -> one csum_ok_o pulse; exp_csum_i="199" -> one csum_err_o pulse.

Source files
------------

// File: rtl/fix_csum_gen.sv
// fix_csum_gen: sums kept message bytes mod 256 and emits the result as three
// ASCII decimal digits (hundreds, tens, units) over a valid/ready handshake.
// Optional build macro FIX_CSUM_CHECK_EN adds an expected-checksum compare
// with one-cycle ok/err pulses on entry to EMIT_H.
module fix_csum_gen #(
  parameter int unsigned LANES = 1,
  parameter logic [7:0]  SEED  = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*LANES-1:0]   data_i,
  input  logic [LANES-1:0]     keep_i,
  input  logic                 valid_i,
  input  logic                 start_i,
  input  logic                 end_i,
  output logic                 ready_o,
  output logic [7:0]           digit_o,
  output logic                 digit_valid_o,
  input  logic                 digit_ready_i,
  output logic                 digit_last_o,
  output logic                 busy_o
`ifdef FIX_CSUM_CHECK_EN
  ,
  input  logic [23:0]          exp_csum_i,
  output logic                 csum_ok_o,
  output logic                 csum_err_o
`endif
);

  typedef enum logic [2:0] {IDLE, ACC, CONV, EMIT_H, EMIT_T, EMIT_U} state_t;

  state_t     state, state_nxt;
  logic [7:0] sum;
  logic [7:0] beat_sum;
  logic       accept;
  logic [7:0] rem;
  logic [7:0] hund;
  logic [7:0] conv_h, conv_t, conv_u;
  logic [7:0] dig_h, dig_t, dig_u;

  assign ready_o = rst && ((state == IDLE) || (state == ACC));
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state != IDLE);

  // Sum of the kept lanes of the current beat, mod 256.
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (keep_i[i]) beat_sum = beat_sum + data_i[8*i +: 8];
    end
  end

  // Decimal split of the running sum into ASCII digits.
  always_comb begin
    hund = '0;
    rem  = sum;
    if (sum >= 8'd200) begin
      hund = 8'd2;
      rem  = sum - 8'd200;
    end else if (sum >= 8'd100) begin
      hund = 8'd1;
      rem  = sum - 8'd100;
    end
    conv_h = 8'h30 + hund;
    conv_t = 8'h30 + rem / 8'd10;
    conv_u = 8'h30 + rem % 8'd10;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && start_i) state_nxt = end_i ? CONV : ACC;
      ACC:    if (accept && end_i)   state_nxt = CONV;
      CONV:   state_nxt = EMIT_H;
      EMIT_H: if (digit_valid_o && digit_ready_i) state_nxt = EMIT_T;
      EMIT_T: if (digit_valid_o && digit_ready_i) state_nxt = EMIT_U;
      EMIT_U: if (digit_valid_o && digit_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Running sum: a start beat reloads from SEED, later beats accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (accept) begin
      if (start_i)            sum <= SEED + beat_sum;
      else if (state == ACC)  sum <= sum + beat_sum;
    end
  end

  // Capture the three digits during CONV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_h <= '0;
      dig_t <= '0;
      dig_u <= '0;
    end else if (state == CONV) begin
      dig_h <= conv_h;
      dig_t <= conv_t;
      dig_u <= conv_u;
    end
  end

  // Registered digit stream. The hundreds digit appears one cycle after
  // EMIT_H is entered; each later digit is loaded on the handshake that
  // leaves the previous EMIT state, so the stream has no bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_o       <= '0;
      digit_valid_o <= 1'b0;
      digit_last_o  <= 1'b0;
    end else begin
      case (state)
        EMIT_H: begin
          if (!digit_valid_o) begin
            digit_o       <= dig_h;
            digit_valid_o <= 1'b1;
            digit_last_o  <= 1'b0;
          end else if (digit_ready_i) begin
            digit_o <= dig_t;
          end
        end
        EMIT_T: begin
          if (digit_valid_o && digit_ready_i) begin
            digit_o      <= dig_u;
            digit_last_o <= 1'b1;
          end
        end
        EMIT_U: begin
          if (digit_valid_o && digit_ready_i) begin
            digit_o       <= '0;
            digit_valid_o <= 1'b0;
            digit_last_o  <= 1'b0;
          end
        end
        default: begin
          digit_o       <= '0;
          digit_valid_o <= 1'b0;
          digit_last_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIX_CSUM_CHECK_EN
  // Compare against the expected checksum sampled in CONV; pulse on EMIT_H entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_ok_o  <= 1'b0;
      csum_err_o <= 1'b0;
    end else if (state == CONV) begin
      csum_ok_o  <= ({conv_h, conv_t, conv_u} == exp_csum_i);
      csum_err_o <= ({conv_h, conv_t, conv_u} != exp_csum_i);
    end else begin
      csum_ok_o  <= 1'b0;
      csum_err_o <= 1'b0;
    end
  end
`else
  // Default build: no expected-checksum compare.
`endif

endmodule

// File: tb/tb_fix_csum_gen.sv
// Self-checking bench for fix_csum_gen (LANES=4, SEED=0): directed messages
// with literal expectations plus randomized traffic against a reference model.
module tb_fix_csum_gen;
  localparam int unsigned LANES = 4;
  localparam logic [7:0]  SEED  = 8'd0;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [8*LANES-1:0]  data_i = '0;
  logic [LANES-1:0]    keep_i = '0;
  logic                valid_i = 1'b0, start_i = 1'b0, end_i = 1'b0;
  logic                ready_o;
  logic [7:0]          digit_o;
  logic                digit_valid_o, digit_last_o, busy_o;
  logic                digit_ready_i = 1'b0;
`ifdef FIX_CSUM_CHECK_EN
  logic [23:0]         exp_csum_i = '0;
  logic                csum_ok_o, csum_err_o;
  int                  nok = 0, nerr = 0;
  logic [23:0]         exp_sampled = '0;
`endif

  always #5 clk = ~clk;

  fix_csum_gen #(.LANES(LANES), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .keep_i(keep_i),
    .valid_i(valid_i), .start_i(start_i), .end_i(end_i), .ready_o(ready_o),
    .digit_o(digit_o), .digit_valid_o(digit_valid_o),
    .digit_ready_i(digit_ready_i), .digit_last_o(digit_last_o), .busy_o(busy_o)
`ifdef FIX_CSUM_CHECK_EN
    , .exp_csum_i(exp_csum_i), .csum_ok_o(csum_ok_o), .csum_err_o(csum_err_o)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 accumulating, 2 converting/emitting.
  int          cyc = 0;
  int          phase = 0, msum = 0, idx = 0, end_cyc = -100;
  logic [7:0]  expq[$];
  logic [23:0] msg_digits = '0;
  logic [23:0] got = '0;
  int          ngot = 0;
  string       s;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int   ph0, kept;
    logic exp_valid;
    if (!rst) begin
      chk("rst_ready", ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_digit", digit_o, 0);
      chk("rst_digit_valid", digit_valid_o, 0);
      chk("rst_digit_last", digit_last_o, 0);
`ifdef FIX_CSUM_CHECK_EN
      chk("rst_csum_ok", csum_ok_o, 0);
      chk("rst_csum_err", csum_err_o, 0);
`endif
      phase = 0;
      idx = 0;
      expq.delete();
    end else begin
      ph0 = phase;
      chk("ready", ready_o, ph0 != 2);
      chk("busy", busy_o, ph0 != 0);
      exp_valid = (ph0 == 2) && (cyc >= end_cyc + 3);
      chk("digit_valid", digit_valid_o, exp_valid);
`ifdef FIX_CSUM_CHECK_EN
      if (ph0 == 2 && cyc == end_cyc + 1) exp_sampled = exp_csum_i;
      chk("csum_ok", csum_ok_o, (ph0 == 2) && (cyc == end_cyc + 2) && (exp_sampled == msg_digits));
      chk("csum_err", csum_err_o, (ph0 == 2) && (cyc == end_cyc + 2) && (exp_sampled != msg_digits));
      if (csum_ok_o) nok++;
      if (csum_err_o) nerr++;
`endif
      if (exp_valid && expq.size() > 0) begin
        chk("digit", digit_o, expq[0]);
        chk("digit_last", digit_last_o, idx == 2);
        if (digit_ready_i) begin
          got = {got[15:0], digit_o};
          ngot++;
          void'(expq.pop_front());
          idx++;
          if (idx == 3) begin
            phase = 0;
            idx = 0;
          end
        end
      end else begin
        chk("digit_last_idle", digit_last_o, 0);
      end
      if (valid_i && ph0 != 2) begin
        kept = 0;
        for (int l = 0; l < LANES; l++)
          if (keep_i[l]) kept += int'(data_i[8*l +: 8]);
        if (start_i) begin
          msum = int'(SEED) + kept;
          phase = 1;
        end else if (ph0 == 1) begin
          msum = msum + kept;
        end
        if (phase == 1 && end_i) begin
          s = $sformatf("%03d", msum % 256);
          msg_digits = {s[0], s[1], s[2]};
          expq.push_back(s[0]);
          expq.push_back(s[1]);
          expq.push_back(s[2]);
          phase = 2;
          end_cyc = cyc;
          idx = 0;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic st, input logic en);
    logic acc;
    acc = 1'b0;
    data_i = d; keep_i = k; start_i = st; end_i = en; valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("beat_accepted", acc, 1);
    valid_i = 1'b0; start_i = 1'b0; end_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      if (phase == 0) break;
      @(posedge clk);
      #1;
    end
    chk("idle_reached", phase == 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic msg_check(input string name, input logic [23:0] req, input int base);
    chk(name, got, req);
    chk({name, "_count"}, ngot - base, 3);
  endtask

  initial begin
    int base;
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    digit_ready_i = 1'b1;

    // "ABC" -> 198
`ifdef FIX_CSUM_CHECK_EN
    exp_csum_i = 24'h313938;
    base = nok;
`endif
    begin
      int b0;
      b0 = ngot;
      drive(32'h41, 4'b0001, 1, 0);
      drive(32'h42, 4'b0001, 0, 0);
      drive(32'h43, 4'b0001, 0, 1);
      wait_idle();
      msg_check("msg_198", 24'h313938, b0);
    end
`ifdef FIX_CSUM_CHECK_EN
    chk("ok_pulses_198", nok - base, 1);
    exp_csum_i = 24'h313939;
    base = nerr;
    drive(32'h41, 4'b0001, 1, 0);
    drive(32'h42, 4'b0001, 0, 0);
    drive(32'h43, 4'b0001, 0, 1);
    wait_idle();
    chk("err_pulses_199", nerr - base, 1);
`endif

    // 0xFF + 0x02 wraps to 1
    base = ngot;
    drive(32'hFF, 4'b0001, 1, 0);
    drive(32'h02, 4'b0001, 0, 1);
    wait_idle();
    msg_check("msg_001", 24'h303031, base);

    // single beat, two lanes kept: 0x10 + 0x20 = 48
    base = ngot;
    drive(32'hEEDD2010, 4'b0011, 1, 1);
    wait_idle();
    msg_check("msg_048", 24'h303438, base);

    // nothing kept -> 000
    base = ngot;
    drive(32'hFFFFFFFF, 4'b0000, 1, 1);
    wait_idle();
    msg_check("msg_000", 24'h303030, base);

    // 255
    base = ngot;
    drive(32'h000000FF, 4'b0001, 1, 1);
    wait_idle();
    msg_check("msg_255", 24'h323535, base);

    // stray non-start beat then restart mid-message: 0x50 ignored, 0x07 dropped
    base = ngot;
    drive(32'h50, 4'b0001, 0, 1);
    drive(32'h07, 4'b0001, 1, 0);
    drive(32'h05, 4'b0001, 1, 0);
    drive(32'h06, 4'b0001, 0, 1);
    wait_idle();
    msg_check("msg_011", 24'h303131, base);

    // back-pressure in EMIT_T, then reset aborts the message
    digit_ready_i = 1'b0;
    base = ngot;
    drive(32'h41, 4'b0001, 1, 0);
    drive(32'h42, 4'b0001, 0, 0);
    drive(32'h43, 4'b0001, 0, 1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (digit_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("first_digit_seen", seen, 1);
    digit_ready_i = 1'b1;
    @(posedge clk);
    #1;
    digit_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_tens_digit", digit_o, 8'h39);
    chk("hold_tens_valid", digit_valid_o, 1);
    chk("hold_ready_low", ready_o, 0);
    rst = 1'b0;
    #1;
    chk("abort_digit", digit_o, 0);
    chk("abort_valid", digit_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    digit_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_digit_count", ngot - base, 1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 599) != 0);
      valid_i       = ($urandom_range(0, 1) == 1);
      start_i       = ($urandom_range(0, 3) == 0);
      end_i         = ($urandom_range(0, 2) == 0);
      keep_i        = 4'($urandom);
      data_i        = $urandom;
      digit_ready_i = ($urandom_range(0, 9) < 7);
`ifdef FIX_CSUM_CHECK_EN
      exp_csum_i    = ($urandom_range(0, 1) == 1) ? msg_digits : 24'($urandom);
`endif
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    valid_i = 1'b0;
    digit_ready_i = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
